// File: rtl/seg_scan_ctrl_if.sv
// Load port for the display sequencer: one 4-digit BCD set offered with valid/ready.
interface seg_scan_ctrl_if;
  logic       load_valid;
  logic       load_ready;
  logic [3:0] load_d1;
  logic [3:0] load_d2;
  logic [3:0] load_d3;
  logic [3:0] load_d4;

  modport master (output load_valid, output load_d1, output load_d2,
                  output load_d3, output load_d4, input load_ready);
  modport slave  (input load_valid, input load_d1, input load_d2,
                  input load_d3, input load_d4, output load_ready);
endinterface

// File: rtl/seg_scan_ctrl.sv
// 4-digit display scan sequencer: blank/show slots per digit, frame-aligned
// commit of newly loaded digits, and leading-zero blanking on the anodes.
module seg_scan_ctrl #(
  parameter int unsigned ON_CYCLES    = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  lzb,
  seg_scan_ctrl_if.slave        ld,
  output logic [3:0]            digit1,
  output logic [3:0]            digit2,
  output logic [3:0]            digit3,
  output logic [3:0]            digit4,
  output logic [1:0]            refresh_counter,
  output logic [3:0]            anode,
  output logic                  frame_done
);

  localparam int unsigned MAX_CYC = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic {ST_BLANK, ST_SHOW} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           rc_q, rc_d;
  logic [3:0]           anode_q, anode_d;
  logic                 fd_q, fd_d;
  logic [3:0][3:0]      digit_q, digit_d;
  logic [3:0][3:0]      pdig_q, pdig_d;
  logic                 pend_q, pend_d;
  logic                 ready_q, ready_d;
  logic                 boundary;
  logic                 commit;
  logic [3:0]           supp;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      rc_q    <= 2'd0;
      anode_q <= 4'hf;
      fd_q    <= 1'b0;
      digit_q <= '0;
      pdig_q  <= '0;
      pend_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rc_q    <= rc_d;
      anode_q <= anode_d;
      fd_q    <= fd_d;
      digit_q <= digit_d;
      pdig_q  <= pdig_d;
      pend_q  <= pend_d;
      ready_q <= ready_d;
    end
  end

  // Next-state, load handshake, commit and anode decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rc_d     = rc_q;
    digit_d  = digit_q;
    pdig_d   = pdig_q;
    pend_d   = pend_q;
    boundary = 1'b0;
    fd_d     = 1'b0;
    anode_d  = 4'hf;
    supp     = 4'b0000;

    if (!en) begin
      state_d = ST_BLANK;
      cnt_d   = '0;
      rc_d    = 2'd0;
    end else begin
      case (state_q)
        ST_BLANK: begin
          if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_SHOW: begin
          if (cnt_q == CNT_W'(ON_CYCLES - 1)) begin
            state_d  = ST_BLANK;
            cnt_d    = '0;
            rc_d     = rc_q + 2'd1;
            boundary = (rc_q == 2'd3);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_BLANK;
          cnt_d   = '0;
        end
      endcase
    end

    fd_d   = boundary;
    // While disabled there are no frames, so a pending set commits at once
    commit = pend_q && (boundary || !en);

    if (commit) begin
      digit_d = pdig_q;
      pend_d  = 1'b0;
    end else if (ld.load_valid && ready_q) begin
      pdig_d = {ld.load_d4, ld.load_d3, ld.load_d2, ld.load_d1};
      pend_d = 1'b1;
    end
    ready_d = ~pend_d;

    // A digit is blanked when it and all higher digits are zero; digit1 always shows
    supp[3] = lzb && (digit_d[3] == 4'h0);
    supp[2] = supp[3] && (digit_d[2] == 4'h0);
    supp[1] = supp[2] && (digit_d[1] == 4'h0);
    supp[0] = 1'b0;

    if (state_d == ST_SHOW && !supp[rc_d]) begin
      anode_d = ~(4'b0001 << rc_d);
    end
  end

  assign digit1          = digit_q[0];
  assign digit2          = digit_q[1];
  assign digit3          = digit_q[2];
  assign digit4          = digit_q[3];
  assign refresh_counter = rc_q;
  assign anode           = anode_q;
  assign frame_done      = fd_q;
  assign ld.load_ready   = ready_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with ON_CYCLES=4, BLANK_CYCLES=2 (6-clock slot, 24-clock frame).
module tb_seg_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       lzb;
  logic [3:0] digit1, digit2, digit3, digit4;
  logic [1:0] refresh_counter;
  logic [3:0] anode;
  logic       frame_done;

  int errors = 0;
  int checks = 0;
  int k      = 0;

  seg_scan_ctrl_if ld_if ();

  seg_scan_ctrl #(.ON_CYCLES(4), .BLANK_CYCLES(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en              (en),
    .lzb             (lzb),
    .ld              (ld_if),
    .digit1          (digit1),
    .digit2          (digit2),
    .digit3          (digit3),
    .digit4          (digit4),
    .refresh_counter (refresh_counter),
    .anode           (anode),
    .frame_done      (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at k=%0d: got %h expected %h", tag, k, got, exp);
    end
  endtask

  // Expected anode k clocks after scanning started: slot = k/6, SHOW on phases 2..5
  function automatic logic [3:0] exp_anode(input int kk, input logic [3:0] lit);
    int p;
    int d;
    logic [3:0] r;
    p = kk % 6;
    d = (kk / 6) % 4;
    r = 4'hf;
    if (p >= 2 && lit[d]) r[d] = 1'b0;
    return r;
  endfunction

  function automatic logic [15:0] digs();
    return {digit4, digit3, digit2, digit1};
  endfunction

  task automatic run_to(input int target, input logic [3:0] lit);
    while (k < target) begin
      @(posedge clk);
      #1;
      k++;
      chk("anode", 32'(anode), 32'(exp_anode(k, lit)));
      chk("refresh_counter", 32'(refresh_counter), 32'((k / 6) % 4));
      chk("frame_done", 32'(frame_done), 32'((k > 0) && (k % 24 == 0)));
    end
  endtask

  task automatic offer(input logic [15:0] v);
    ld_if.load_valid = 1'b1;
    ld_if.load_d1 = v[3:0];
    ld_if.load_d2 = v[7:4];
    ld_if.load_d3 = v[11:8];
    ld_if.load_d4 = v[15:12];
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    lzb   = 1'b0;
    ld_if.load_valid = 1'b0;
    ld_if.load_d1 = 4'h0;
    ld_if.load_d2 = 4'h0;
    ld_if.load_d3 = 4'h0;
    ld_if.load_d4 = 4'h0;

    #22;
    chk("rst_anode", 32'(anode), 32'h f);
    chk("rst_rc", 32'(refresh_counter), 32'h0);
    chk("rst_ready", 32'(ld_if.load_ready), 32'h1);
    chk("rst_fd", 32'(frame_done), 32'h0);
    chk("rst_digits", 32'(digs()), 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    k = 0;

    // Plain scan for two frames, then load 1,2,3,4 mid-frame
    run_to(50, 4'hf);
    offer(16'h4321);
    run_to(51, 4'hf);
    chk("ready_drop", 32'(ld_if.load_ready), 32'h0);
    chk("no_early_commit", 32'(digs()), 32'h0);
    offer(16'h8765);
    run_to(71, 4'hf);
    chk("hold_before_boundary", 32'(digs()), 32'h0);
    chk("backpressure_ready", 32'(ld_if.load_ready), 32'h0);
    run_to(72, 4'hf);
    chk("commit_1234", 32'(digs()), 32'h4321);
    chk("ready_after_commit", 32'(ld_if.load_ready), 32'h1);
    run_to(73, 4'hf);
    chk("capture_after_commit", 32'(ld_if.load_ready), 32'h0);
    ld_if.load_valid = 1'b0;
    run_to(95, 4'hf);
    chk("one_frame_1234", 32'(digs()), 32'h4321);
    run_to(96, 4'hf);
    chk("commit_5678", 32'(digs()), 32'h8765);

    // Leading-zero blanking: 0042 lights digit1/2, 0000 lights digit1 only
    lzb = 1'b1;
    offer(16'h0042);
    run_to(97, 4'hf);
    ld_if.load_valid = 1'b0;
    run_to(120, 4'hf);
    chk("commit_0042", 32'(digs()), 32'h0042);
    offer(16'h0000);
    run_to(121, 4'b0011);
    ld_if.load_valid = 1'b0;
    run_to(144, 4'b0011);
    chk("commit_0000", 32'(digs()), 32'h0000);
    run_to(168, 4'b0001);
    lzb = 1'b0;
    run_to(192, 4'hf);

    // Disable during digit3 SHOW with a load pending (non-BCD digits)
    run_to(200, 4'hf);
    offer(16'hDCBA);
    run_to(201, 4'hf);
    ld_if.load_valid = 1'b0;
    chk("pend_before_disable", 32'(ld_if.load_ready), 32'h0);
    run_to(206, 4'hf);
    chk("digit3_show", 32'(anode), 32'h b);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("dis_anode", 32'(anode), 32'h f);
      chk("dis_rc", 32'(refresh_counter), 32'h0);
      chk("dis_fd", 32'(frame_done), 32'h0);
      chk("dis_commit", 32'(digs()), 32'hDCBA);
      chk("dis_ready", 32'(ld_if.load_ready), 32'h1);
    end
    en = 1'b1;
    k = 0;
    run_to(24, 4'hf);

    // Asynchronous reset in digit2 SHOW with a load pending
    offer(16'h1111);
    run_to(25, 4'hf);
    ld_if.load_valid = 1'b0;
    run_to(32, 4'hf);
    chk("pre_rst_anode", 32'(anode), 32'h d);
    chk("pre_rst_ready", 32'(ld_if.load_ready), 32'h0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_anode", 32'(anode), 32'h f);
    chk("arst_rc", 32'(refresh_counter), 32'h0);
    chk("arst_ready", 32'(ld_if.load_ready), 32'h1);
    chk("arst_digits", 32'(digs()), 32'h0);
    chk("arst_fd", 32'(frame_done), 32'h0);
    @(posedge clk);
    #1;
    chk("arst_held", 32'(digs()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
